sha256_stream_core: RTL and testbench

Multi-block SHA-256 compression engine. It is the parametrised successor of the single-block free-running core.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake.
- Chains intermediate hash state across blocks of one message.
- Unrolls ROUNDS_PER_CYCLE compression rounds per clock.
- Presents the final digest on a valid/ready output.
- Sits between the padding/framing unit and the digest consumer.

---
 rtl/sha256_pkg.sv | 64 ++++++
 rtl/sha256_round.sv | 19 +
 rtl/sha256_stream_core.sv | 149 ++++++++++++++
 tb/tb_sha256_stream_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, word/state types and round helper functions
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:7]  hash_t;
    typedef word_t [0:15] sched_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam hash_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round; state element 0 is a, 7 is h
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t s_in,
    input  word_t k,
    input  word_t w,
    output hash_t s_out
);
    word_t t1;
    word_t t2;

    always_comb begin
        t1    = s_in[7] + big_sigma1(s_in[4]) + ch(s_in[4], s_in[5], s_in[6]) + k + w;
        t2    = big_sigma0(s_in[0]) + maj(s_in[0], s_in[1], s_in[2]);
        s_out = {t1 + t2, s_in[0], s_in[1], s_in[2], s_in[3] + t1, s_in[4], s_in[5], s_in[6]};
    end

endmodule

// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - multi-block SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock
// Define SHA224_EN to add the mode_224 input and SHA-224 initial values.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
`ifdef SHA224_EN
    input  logic         mode_224,
`endif
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);
    localparam int R     = ROUNDS_PER_CYCLE;
    localparam int STEPS = 64 / R;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_r
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          msg_open, last_q, accept;
    hash_t         h, work, h_sum, iv, dsel;
    sched_t        w, w_next;
    word_t         ext [16+R];
    hash_t         chain [R+1];
    logic [5:0]    rbase;

    assign accept = blk_valid && blk_ready;
    assign rbase  = 6'(cnt) * 6'(R);

`ifdef SHA224_EN
    logic mode_q;
    assign iv = mode_224 ? IV224 : IV256;

    // Mode is captured only when the IV is (re)loaded, so it sticks for the whole message.
    always_ff @(posedge clk) begin
        if (rst)
            mode_q <= 1'b0;
        else if (accept && (blk_first || !msg_open))
            mode_q <= mode_224;
    end
`else
    assign iv = IV256;
`endif

    always_comb begin
        for (int j = 0; j < 8; j++) h_sum[j] = h[j] + work[j];
        dsel = h_sum;
`ifdef SHA224_EN
        if (mode_q) dsel[7] = '0;
`endif
    end

    // Window extension: the R words consumed this cycle are replaced by R freshly scheduled ones.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < R; j++)
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        for (int i = 0; i < 16; i++) w_next[i] = ext[i+R];
    end

    assign chain[0] = work;
    for (genvar g = 0; g < R; g++) begin : g_round
        sha256_round u_round (
            .s_in  (chain[g]),
            .k     (K[rbase + 6'(g)]),
            .w     (ext[g]),
            .s_out (chain[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == LAST_CNT) state_nxt = FINAL;
            FINAL:   state_nxt = last_q ? OUT : IDLE;
            OUT:     if (digest_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        blk_ready    = 1'b0;
        digest_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                blk_ready = !rst;
                busy      = 1'b0;
            end
            OUT:     digest_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            msg_open <= 1'b0;
            last_q   <= 1'b0;
            digest   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    w <= blk_data;
                    if (blk_first || !msg_open) begin
                        h    <= iv;
                        work <= iv;
                    end else begin
                        work <= h;
                    end
                    last_q <= blk_last;
                    cnt    <= '0;
                end
                RUN: begin
                    work <= chain[R];
                    w    <= w_next;
                    cnt  <= cnt + CW'(1);
                end
                FINAL: begin
                    h        <= h_sum;
                    msg_open <= !last_q;
                    if (last_q) digest <= dsel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb/tb_sha256_stream_core.sv - known vectors plus randomized multi-block messages against a reference hash model
module tb_sha256_stream_core;
    localparam int R   = 4;
    localparam int LAT = 64 / R + 1;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] REF_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
        256'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h1c0};
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         digest_valid;
    logic         digest_ready = 1'b0;
    logic [255:0] digest;
    logic         busy;
`ifdef SHA224_EN
    logic         mode_224 = 1'b0;
`endif

    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] m_h = '0;
    logic         m_open = 1'b0;

    always #5 clk = ~clk;

    sha256_stream_core #(.ROUNDS_PER_CYCLE(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
`ifdef SHA224_EN
        .mode_224     (mode_224),
`endif
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, one round per loop iteration.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  wv [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) wv[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            wv[t] = (rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
                  + (rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + wv[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = v[i] + hin[255-32*i -: 32];
        return res;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    task automatic start_block(input logic [511:0] data, input logic first, input logic last,
                               input string tag, output logic ok);
        int n;
        n = 0;
        @(posedge clk); #1;
        blk_valid = 1'b1;
        blk_data  = data;
        blk_first = first;
        blk_last  = last;
        @(negedge clk);
        while (blk_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (blk_ready === 1'b1);
        if (!ok) check({tag, "_accept_timeout"}, 256'(0), 256'(1));
        else     @(posedge clk);
        #1 blk_valid = 1'b0;
    endtask

    task automatic send_block(input logic [511:0] data, input logic first, input logic last,
                              input logic early, input string tag);
        int   n;
        logic ok;
        if (first || !m_open) m_h = REF_IV;
        m_h    = ref_compress(m_h, data);
        m_open = !last;
        start_block(data, first, last, tag, ok);
        if (!ok) return;
        if (early) digest_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while ((last ? digest_valid : blk_ready) !== 1'b1 && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 256'(n), 256'(LAT));
    endtask

    // Called at the negedge where digest_valid was first seen.
    task automatic take_digest(input logic [255:0] exp, input int hold, input string tag);
        logic [255:0] seen;
        logic         stable, closed;
        seen   = digest;
        stable = 1'b1;
        closed = 1'b1;
        check({tag, "_digest"}, digest, exp);
        if (hold > 0 && !digest_ready) begin
            @(posedge clk); #1;
            blk_valid = 1'b1;
            blk_data  = rand_block();
            blk_first = 1'b1;
            blk_last  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (digest !== seen || digest_valid !== 1'b1) stable = 1'b0;
                if (blk_ready !== 1'b0) closed = 1'b0;
                @(posedge clk);
            end
            #1 blk_valid = 1'b0;
            check({tag, "_hold_stable"}, 256'(stable), 256'(1));
            check({tag, "_hold_blk_ready_low"}, 256'(closed), 256'(1));
        end
        if (!digest_ready) begin
            @(posedge clk);
            #1 digest_ready = 1'b1;
        end
        @(posedge clk);
        #1 digest_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_dropped"}, 256'(digest_valid), 256'(0));
        check({tag, "_digest_kept"}, digest, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_blk_ready", 256'(blk_ready), 256'(0));
        check("rst_digest_valid", 256'(digest_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_digest", digest, 256'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_blk_ready", 256'(blk_ready), 256'(1));

        send_block(BLK_ABC, 1'b1, 1'b1, 1'b0, "abc");
        take_digest(D_ABC, 0, "abc");

        send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b0, "empty");
        take_digest(D_EMPTY, 20, "empty");

        send_block(BLK_TWO1, 1'b1, 1'b0, 1'b0, "two_b1");
        repeat (10) @(posedge clk);
        send_block(BLK_TWO2, 1'b0, 1'b1, 1'b0, "two_b2");
        take_digest(D_TWO, 0, "two");

        send_block(BLK_TWO1, 1'b1, 1'b0, 1'b0, "abandon_b1");
        send_block(BLK_ABC, 1'b1, 1'b1, 1'b0, "abandon_abc");
        take_digest(D_ABC, 0, "abandon");

        // Reset in the middle of a continuation block must also close the open message.
        send_block(BLK_TWO1, 1'b1, 1'b0, 1'b0, "midrst_b1");
        start_block(BLK_TWO2, 1'b0, 1'b1, "midrst_b2", ok);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_open = 1'b0;
        @(negedge clk);
        check("midrst_digest", digest, 256'(0));
        check("midrst_digest_valid", 256'(digest_valid), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_blk_ready", 256'(blk_ready), 256'(1));
        send_block(BLK_ABC, 1'b0, 1'b1, 1'b0, "midrst_abc");
        take_digest(D_ABC, 0, "midrst_abc");

`ifdef SHA224_EN
        mode_224 = 1'b1;
        send_block(BLK_ABC, 1'b1, 1'b1, 1'b0, "sha224");
        take_digest({224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, 0, "sha224");
        mode_224 = 1'b0;
`endif

        for (int m = 0; m < 30; m++) begin
            int   nb, hold;
            logic early, first;
            nb    = $urandom_range(1, 3);
            early = ($urandom_range(0, 3) == 0);
            hold  = early ? 0 : $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                first = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                send_block(rand_block(), first, (b == nb - 1), early && (b == nb - 1), $sformatf("rnd%0d_b%0d", m, b));
            end
            take_digest(m_h, hold, $sformatf("rnd%0d", m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
